// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the I/D cache memory-port arbiter.
package cache_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one memory port.
// Define ARB_ROUND_ROBIN_EN to alternate winners on ties; default is fixed D-over-I.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [1:0]        o_dbg_state
);

  // Handshake: requesters hold read/write level-high until their one-cycle
  // resp pulse; memory holds the request until mem_resp, which completes it.
  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_write;
  logic              w_i_req;
  logic              w_d_req;
  logic              w_pick_d;
  logic              w_grant;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;
  assign w_grant = (r_state == IDLE) & (w_i_req | w_d_req);

`ifdef ARB_ROUND_ROBIN_EN
  req_t r_last_grant;

  // Reset value REQ_I makes D the winner of the first tie.
  assign w_pick_d = w_d_req & (~w_i_req | (r_last_grant == REQ_I));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= REQ_I;
    end else if (w_grant) begin
      r_last_grant <= w_pick_d ? REQ_D : REQ_I;
    end
  end
`else
  assign w_pick_d = w_d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_next_state = BUSY_D;
        end else if (w_i_req) begin
          w_next_state = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_resp) begin
          w_next_state = RELEASE;
        end
      end
      RELEASE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The in-flight transaction is frozen here so later request changes cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_grant) begin
      r_addr  <= w_pick_d ? d_addr : i_addr;
      r_write <= w_pick_d & d_write;
      r_wdata <= (w_pick_d & d_write) ? d_wdata : '0;
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    i_rdata   = '0;
    d_resp    = 1'b0;
    d_rdata   = '0;
    case (r_state)
      BUSY_I, BUSY_D: begin
        mem_read  = ~r_write;
        mem_write = r_write;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      default: ;
    endcase
    if ((r_state == BUSY_I) && mem_resp) begin
      i_resp  = 1'b1;
      i_rdata = mem_rdata;
    end
    if ((r_state == BUSY_D) && mem_resp) begin
      d_resp  = 1'b1;
      d_rdata = mem_rdata;
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: reset, single I/D transactions, priority,
// grant ordering, mid-transaction reset and request stability.
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic [1:0]    o_dbg_state;

  int n_vec;
  int n_err;
  logic [0:0] exp_q[$];

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive_idle();
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    i_read = 1'b1; i_addr = 32'h0000_0100;
    d_write = 1'b1; d_addr = 32'h0000_0200;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (o_dbg_state !== IDLE) begin
      n_err++; $display("FAIL rst_state: got %0d required %0d", o_dbg_state, IDLE);
    end
    n_vec++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      n_err++; $display("FAIL rst_ctrl: got %b required 0000", {mem_read, mem_write, i_resp, d_resp});
    end
    n_vec++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_err++; $display("FAIL rst_addr: got %0h required 0", mem_addr);
    end
    drive_idle();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_i_read();
    logic [LW-1:0] pat;
    pat = {32{8'hA5}};
    do_reset();
    i_read = 1'b1; i_addr = 32'h0000_1000;
    @(negedge clk);
    n_vec++;
    if (mem_read !== 1'b0) begin
      n_err++; $display("FAIL i_lat_n: got %b required 0", mem_read);
    end
    @(posedge clk); #1 i_read = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h0000_1000) begin
      n_err++; $display("FAIL i_lat_n1: got rd=%b wr=%b addr=%0h required rd=1 wr=0 addr=1000", mem_read, mem_write, mem_addr);
    end
    n_vec++;
    if (o_dbg_state !== BUSY_I || i_rdata !== '0) begin
      n_err++; $display("FAIL i_busy: got state=%0d rdata_nz=%b required state=%0d rdata_nz=0", o_dbg_state, |i_rdata, BUSY_I);
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (mem_read !== 1'b1 || mem_addr !== 32'h0000_1000) begin
        n_err++; $display("FAIL i_hold: got rd=%b addr=%0h required rd=1 addr=1000", mem_read, mem_addr);
      end
    end
    @(posedge clk); #1 mem_resp = 1'b1; mem_rdata = pat;
    @(negedge clk);
    n_vec++;
    if (i_resp !== 1'b1 || i_rdata !== pat || d_resp !== 1'b0 || d_rdata !== '0) begin
      n_err++; $display("FAIL i_resp: got i_resp=%b d_resp=%b rdata=%0h required 1 0 %0h", i_resp, d_resp, i_rdata, pat);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (o_dbg_state !== RELEASE || i_resp !== 1'b0 || i_rdata !== '0 || mem_read !== 1'b0) begin
      n_err++; $display("FAIL i_release: got state=%0d i_resp=%b rd=%b required state=%0d 0 0", o_dbg_state, i_resp, mem_read, RELEASE);
    end
    @(posedge clk); #1 mem_resp = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_dbg_state !== IDLE || i_resp !== 1'b0) begin
      n_err++; $display("FAIL i_back_idle: got state=%0d i_resp=%b required %0d 0", o_dbg_state, i_resp, IDLE);
    end
  endtask

  task automatic test_d_write();
    logic [LW-1:0] pat;
    pat = {8{32'h1234_5678}};
    do_reset();
    d_write = 1'b1; d_addr = 32'h0000_2040; d_wdata = pat;
    @(posedge clk); #1 d_write = 1'b0; d_wdata = {LW{1'b1}};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h0000_2040 || mem_wdata !== pat) begin
        n_err++; $display("FAIL d_wr_hold%0d: got wr=%b rd=%b addr=%0h wdata=%0h required 1 0 2040 %0h", c, mem_write, mem_read, mem_addr, mem_wdata, pat);
      end
      @(posedge clk); #1;
    end
    mem_resp = 1'b1; mem_rdata = '0;
    @(negedge clk);
    n_vec++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || mem_wdata !== pat || mem_read !== 1'b0) begin
      n_err++; $display("FAIL d_wr_resp: got d_resp=%b i_resp=%b rd=%b required 1 0 0", d_resp, i_resp, mem_read);
    end
    @(posedge clk); #1 mem_resp = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_dbg_state !== RELEASE || mem_write !== 1'b0 || d_resp !== 1'b0) begin
      n_err++; $display("FAIL d_wr_release: got state=%0d wr=%b d_resp=%b required %0d 0 0", o_dbg_state, mem_write, d_resp, RELEASE);
    end
  endtask

  task automatic test_rw_both();
    logic [LW-1:0] pat;
    pat = {16{16'hBEEF}};
    do_reset();
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_2080; d_wdata = pat;
    @(posedge clk); #1 d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== pat || mem_addr !== 32'h0000_2080) begin
      n_err++; $display("FAIL rw_both: got wr=%b rd=%b addr=%0h required 1 0 2080", mem_write, mem_read, mem_addr);
    end
    @(posedge clk); #1 mem_resp = 1'b1;
    @(posedge clk); #1 mem_resp = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_priority();
    int pulses;
    bit ok;
    pulses = 0;
    do_reset();
    i_read = 1'b1; i_addr = 32'h0000_4000;
    d_read = 1'b1; d_addr = 32'h0000_3000;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (o_dbg_state !== BUSY_D || mem_addr !== 32'h0000_3000 || mem_read !== 1'b1) begin
      n_err++; $display("FAIL prio_d_first: got state=%0d addr=%0h required %0d 3000", o_dbg_state, mem_addr, BUSY_D);
    end
    @(posedge clk); #1 mem_resp = 1'b1; mem_rdata = {8{32'hDDDD_0000}};
    @(negedge clk);
    n_vec++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== {8{32'hDDDD_0000}}) begin
      n_err++; $display("FAIL prio_d_resp: got d_resp=%b i_resp=%b required 1 0", d_resp, i_resp);
    end
    @(posedge clk); #1 mem_resp = 1'b0; d_read = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_dbg_state !== RELEASE || mem_read !== 1'b0) begin
      n_err++; $display("FAIL prio_release: got state=%0d rd=%b required %0d 0", o_dbg_state, mem_read, RELEASE);
    end
    wait_busy(ok);
    n_vec++;
    if (!ok || o_dbg_state !== BUSY_I || mem_addr !== 32'h0000_4000) begin
      n_err++; $display("FAIL prio_i_second: got ok=%b state=%0d addr=%0h required 1 %0d 4000", ok, o_dbg_state, mem_addr, BUSY_I);
    end
    @(posedge clk); #1 mem_resp = 1'b1; mem_rdata = {8{32'hCCCC_1111}};
    @(negedge clk);
    if (i_resp === 1'b1) pulses++;
    @(posedge clk); #1 mem_resp = 1'b0; i_read = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (i_resp === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++; $display("FAIL prio_i_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_grant_order();
    bit ok;
    logic [0:0] got_d;
    logic [0:0] exp_d;
    do_reset();
    exp_q.delete();
`ifdef ARB_ROUND_ROBIN_EN
    for (int g = 0; g < 6; g++) exp_q.push_back((g % 2 == 0) ? 1'b1 : 1'b0);
`else
    for (int g = 0; g < 6; g++) exp_q.push_back(1'b1);
`endif
    i_read = 1'b1; i_addr = 32'h0000_4000;
    d_read = 1'b1; d_addr = 32'h0000_3000;
    for (int g = 0; g < 6; g++) begin
      wait_busy(ok);
      if (!ok) begin
        n_vec++; n_err++;
        $display("FAIL grant_timeout%0d: got no request required a grant", g);
        break;
      end
      got_d = (mem_addr == 32'h0000_3000) ? 1'b1 : 1'b0;
      exp_d = exp_q.pop_front();
      n_vec++;
      if (got_d !== exp_d) begin
        n_err++; $display("FAIL grant%0d: got d=%b required d=%b", g, got_d, exp_d);
      end
      @(posedge clk); #1 mem_resp = 1'b1;
      @(negedge clk);
      n_vec++;
      if ((got_d ? d_resp : i_resp) !== 1'b1 || (got_d ? i_resp : d_resp) !== 1'b0) begin
        n_err++; $display("FAIL grant_resp%0d: got i=%b d=%b required only d=%b", g, i_resp, d_resp, got_d);
      end
      @(posedge clk); #1 mem_resp = 1'b0;
    end
    drive_idle();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    d_read = 1'b1; d_addr = 32'h0000_6000;
    wait_busy(ok);
    d_read = 1'b0;
    n_vec++;
    if (!ok || o_dbg_state !== BUSY_D) begin
      n_err++; $display("FAIL rmid_busy: got ok=%b state=%0d required 1 %0d", ok, o_dbg_state, BUSY_D);
    end
    @(posedge clk); #3 rst = 1'b0;
    #1;
    n_vec++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || o_dbg_state !== IDLE) begin
      n_err++; $display("FAIL rmid_async: got rd=%b wr=%b state=%0d required 0 0 %0d", mem_read, mem_write, o_dbg_state, IDLE);
    end
    @(posedge clk); #1 rst = 1'b1; mem_resp = 1'b1; mem_rdata = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    n_vec++;
    if (d_resp !== 1'b0 || i_resp !== 1'b0 || d_rdata !== '0 || o_dbg_state !== IDLE) begin
      n_err++; $display("FAIL rmid_late_resp: got d_resp=%b i_resp=%b state=%0d required 0 0 %0d", d_resp, i_resp, o_dbg_state, IDLE);
    end
    @(posedge clk); #1 mem_resp = 1'b0; i_read = 1'b1; i_addr = 32'h0000_7000;
    @(posedge clk); #1 i_read = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h0000_7000 || o_dbg_state !== BUSY_I) begin
      n_err++; $display("FAIL rmid_new_i: got rd=%b addr=%0h state=%0d required 1 7000 %0d", mem_read, mem_addr, o_dbg_state, BUSY_I);
    end
    @(posedge clk); #1 mem_resp = 1'b1; mem_rdata = {8{32'h0F0F_0F0F}};
    @(negedge clk);
    n_vec++;
    if (i_resp !== 1'b1 || i_rdata !== {8{32'h0F0F_0F0F}}) begin
      n_err++; $display("FAIL rmid_i_resp: got i_resp=%b rdata=%0h required 1 0f0f..", i_resp, i_rdata);
    end
    @(posedge clk); #1 mem_resp = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_addr_change();
    do_reset();
    i_read = 1'b1; i_addr = 32'h0000_1000;
    @(posedge clk); #1 i_addr = 32'h0000_5000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (mem_addr !== 32'h0000_1000 || mem_read !== 1'b1) begin
        n_err++; $display("FAIL addr_hold%0d: got addr=%0h rd=%b required 1000 1", c, mem_addr, mem_read);
      end
      @(posedge clk); #1;
    end
    mem_resp = 1'b1; i_read = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_addr !== 32'h0000_1000 || i_resp !== 1'b1) begin
      n_err++; $display("FAIL addr_resp: got addr=%0h i_resp=%b required 1000 1", mem_addr, i_resp);
    end
    @(posedge clk); #1 mem_resp = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    drive_idle();
    test_reset();
    test_i_read();
    test_d_write();
    test_rw_both();
    test_priority();
    test_grant_order();
    test_reset_mid();
    test_addr_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
